// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample path: sample width and reader FSM encoding.
package fir_pkg;

   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      VALID   = 2'd3
   } state_t;

endpackage

// File: rtl/fir_fifo_reader.sv
// Pops one sample at a time from a FIFO with a registered empty flag and
// presents it to the FIR core over a valid/ready handshake.
module fir_fifo_reader
   import fir_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int CNT_W = 16
) (
   input  logic                    clk2,
   input  logic                    rst2,
   input  logic                    enable,
   input  logic                    fifo_empty,
   output logic                    fifo_ren,
   input  logic signed [WIDTH-1:0] fifo_dout,
   output logic                    s_valid,
   input  logic                    s_ready,
   output logic signed [WIDTH-1:0] s_data,
   output logic [CNT_W-1:0]        s_cnt,
   output logic                    busy
);

   state_t state;
   logic   armed;
   logic   can_issue;

   // armed holds off the first ISSUE until the second edge after reset release
   assign can_issue = enable && !fifo_empty && armed;

   always_ff @(posedge clk2 or posedge rst2) begin
      if (rst2) begin
         state  <= IDLE;
         armed  <= 1'b0;
         s_data <= '0;
         s_cnt  <= '0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE:    if (can_issue) state <= ISSUE;
            ISSUE:   state <= CAPTURE;
            CAPTURE: begin
               s_data <= fifo_dout;
               state  <= VALID;
            end
            VALID:   if (s_ready) begin
               s_cnt <= s_cnt + CNT_W'(1);
               state <= can_issue ? ISSUE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ISSUE -> CAPTURE -> VALID spacing keeps read pulses >= 3 cycles apart,
   // which absorbs the one-cycle lag of the FIFO empty flag.
   assign fifo_ren = (state == ISSUE);
   assign s_valid  = (state == VALID);
   assign busy     = (state != IDLE);

endmodule

// File: doc/fir_fifo_reader.md
FIR_FIFO_READER -- requirements
Module: fir_fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter CNT_W, default 16: width of delivered-sample counter.
REQ-003 SHALL have port clk2, input, 1: 100 MHz core clock; the only clock.
REQ-004 SHALL have port rst2, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1: permits new FIFO pops.
REQ-006 SHALL have port fifo_empty, input, 1: registered empty flag from the FIFO read side.
REQ-007 SHALL have port fifo_ren, output, 1: FIFO read enable.
REQ-008 SHALL have port fifo_dout, input, WIDTH: signed FIFO read data, valid the cycle after a FIFO read.
REQ-009 SHALL have port s_valid, output, 1: a sample is presented to the FIR core.
REQ-010 SHALL have port s_ready, input, 1: the FIR core accepts the sample.
REQ-011 SHALL have port s_data, output, WIDTH: signed sample to the FIR core.
REQ-012 SHALL have port s_cnt, output, CNT_W: count of accepted samples.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL use FSM states IDLE, ISSUE, CAPTURE, VALID.
REQ-015 IDLE -> ISSUE when enable=1 and fifo_empty=0; otherwise SHALL stay in IDLE.
REQ-016 ISSUE SHALL drive fifo_ren=1 for exactly that one cycle, then SHALL always go to CAPTURE.
REQ-017 fifo_ren SHALL be decoded from the state register only and SHALL be 0 in all other states.
REQ-018 CAPTURE SHALL latch fifo_dout into s_data at the end of the cycle, then SHALL always go to VALID.
REQ-019 VALID SHALL hold s_valid=1 with s_data stable until s_ready=1.
REQ-020 On a VALID handshake, next state SHALL be ISSUE if enable=1 and fifo_empty=0, else IDLE.
REQ-021 fifo_ren SHALL never be high in two consecutive cycles, and consecutive pulses SHALL be at least 3 cycles apart; this covers the one-cycle lag of the FIFO empty flag.
REQ-022 Latency: fifo_empty seen low in IDLE at cycle t -> fifo_ren high at t+1 -> s_valid high at t+3.
REQ-023 enable falling SHALL block only new ISSUE entries; a read already in ISSUE/CAPTURE SHALL complete and be delivered.
REQ-024 s_cnt SHALL increment by 1 on each cycle with s_valid and s_ready both high.
REQ-025 s_cnt SHALL wrap from all-ones to 0 with no flag.
REQ-026 s_data SHALL pass through bit-exact (sign preserved) and SHALL change only at the end of CAPTURE.
REQ-027 s_ready while not in VALID SHALL be ignored.
REQ-028 fifo_empty rising in the same cycle as an ISSUE transition SHALL NOT cancel the ISSUE; the FIFO's own guard discards the read, and the bench SHALL NOT create this case since only this block pops.

Reset
REQ-029 rst2=1 SHALL asynchronously force state IDLE, fifo_ren=0, s_valid=0, s_data=0, s_cnt=0, busy=0.
REQ-030 Reset asserted mid-operation (ISSUE/CAPTURE/VALID) SHALL drop any in-flight sample.
REQ-031 After reset release, the first ISSUE SHALL occur no earlier than the second clk2 edge.

Structure
REQ-032 A shared package fir_pkg SHALL hold SAMPLE_W=16 and the 2-bit FSM state encoding (IDLE=0, ISSUE=1, CAPTURE=2, VALID=3).
REQ-033 The FIFO read-side ports SHALL match the FIFO width (WIDTH) and flag semantics exactly.
REQ-034 This SHALL be a single module; no sub-module is required.

Verification
REQ-035 Reset: rst2 pulsed mid-VALID with s_data=0x1234 -> same cycle s_valid=0, s_data=0, s_cnt=0, fifo_ren=0.
REQ-036 Single sample: FIFO preloaded with 0x8001, enable=1, s_ready=1 -> fifo_ren one cycle; s_valid at t+3 with s_data=0x8001 (-32767); s_cnt=1; back to IDLE.
REQ-037 Burst: 8 samples -32768..-32761 and s_ready=1 -> in-order delivery; fifo_ren pulses exactly 3 cycles apart; fifo_ren never high in two consecutive cycles; s_cnt=8.
REQ-038 Backpressure: s_ready=0 for 10 cycles in VALID with s_data=0x7FFF -> s_valid and s_data held; no fifo_ren pulse; one delivery on release.
REQ-039 enable drop: enable falls in the cycle fifo_ren=1 -> that sample is delivered; no further fifo_ren while enable=0 with a non-empty FIFO.
REQ-040 Wrap: CNT_W=4, 17 accepted samples -> s_cnt reads 15 then 0 then 1.
